// File: rtl/audio_sample_streamer.sv
// audio_sample_streamer: real-time playback sequencer for a single-port sample ROM.
// Fetches one 16-bit word every CLK_DIV clocks, captures it a cycle later and
// presents it on a valid/ready stream. Samples that arrive while the output is
// still full are discarded and counted, because playback cannot slip in time.
module audio_sample_streamer #(
  parameter int CLK_DIV     = 1134,
  parameter int NUM_SAMPLES = 32000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [31:0] rom_addr,
  input  logic [15:0] rom_rd,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] drop_cnt
);

  localparam int IW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IW-1:0] LAST    = IW'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0] TICK_AT = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, WAIT_TICK} state_t;

  state_t        state;
  logic [IW-1:0] index;
  logic [CW-1:0] cnt;
  logic          tick, xfer, can_load;

  assign tick     = (cnt == TICK_AT);
  assign xfer     = sample_valid && sample_ready;
  // Output slot is free if empty or being drained this very cycle.
  assign can_load = !sample_valid || sample_ready;

  // Playback FSM, sample-period counter and output register in one place so
  // stop/done/capture interactions resolve with a single priority order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      index        <= '0;
      cnt          <= '0;
      rom_addr     <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && stop) begin
        // Abort: rom_addr keeps its last value, pending sample is flushed.
        state        <= IDLE;
        busy         <= 1'b0;
        sample_valid <= 1'b0;
        cnt          <= '0;
      end else begin
        if (state != CAPTURE && xfer) sample_valid <= 1'b0;
        if (state != IDLE) cnt <= tick ? '0 : cnt + 1'b1;
        case (state)
          IDLE: begin
            if (start && !stop) begin
              state    <= FETCH;
              busy     <= 1'b1;
              index    <= '0;
              cnt      <= '0;
              drop_cnt <= '0;
              rom_addr <= '0;
            end
          end
          FETCH: state <= CAPTURE;
          CAPTURE: begin
            if (can_load) begin
              sample_data  <= rom_rd;
              sample_valid <= 1'b1;
            end else if (drop_cnt != 16'hFFFF) begin
              drop_cnt <= drop_cnt + 1'b1;
            end
            if (index != LAST) begin
              index <= index + 1'b1;
              state <= WAIT_TICK;
            end else if (loop_en) begin
              index <= '0;
              state <= WAIT_TICK;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              cnt   <= '0;
            end
          end
          WAIT_TICK: begin
            if (tick) begin
              state    <= FETCH;
              rom_addr <= {30'(index), 2'b00};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Bench for audio_sample_streamer: small ROM model, cycle table for start-up
// latency, scoreboard queue of expected samples checked on every transfer.
module tb_audio_sample_streamer;

  localparam int CD = 4;
  localparam int NS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, loop_en, sample_ready;
  logic [31:0] rom_addr;
  logic [15:0] rom_rd = '0;
  logic [15:0] sample_data;
  logic        sample_valid, busy, done;
  logic [15:0] drop_cnt;

  logic [15:0] rom [0:NS-1];
  logic [15:0] exp_q [$];
  int checks = 0, errors = 0, xfers = 0, done_cnt = 0;

  typedef struct {
    logic        start;
    logic        ready;
    logic        busy;
    logic [31:0] addr;
    logic        valid;
    logic [15:0] data;
  } vec_t;
  vec_t vt [8];

  audio_sample_streamer #(.CLK_DIV(CD), .NUM_SAMPLES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // ROM: data valid the cycle after the address is sampled
  always @(posedge clk) rom_rd <= rom[rom_addr[4:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Scoreboard: every transfer pops one expected sample
  always @(negedge clk) begin
    if (rst_n && sample_valid && sample_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer actual=%h required=none", sample_data);
      end else begin
        chk("xfer_data", 32'(sample_data), 32'(exp_q.pop_front()));
      end
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
    chk(nm, 32'(busy), 32'd0);
    cyc();
    cyc();
  endtask

  task automatic push_clip();
    for (int i = 0; i < NS; i++) exp_q.push_back(rom[i]);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) rom[i] = 16'h8001 + 16'(i) * 16'h1357;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; sample_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_addr",  rom_addr, 32'd0);
    chk("rst_data",  32'(sample_data), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_drop",  32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    cyc();

    // start-up latency table, cycle S..S+7, ready held high
    vt[0] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 16'd0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 16'd0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 16'd0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b1, rom[0]};
    vt[4] = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 16'd0};
    vt[5] = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 16'd0};
    vt[6] = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 16'd0};
    vt[7] = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b1, rom[1]};
    push_clip();
    xfers = 0; done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("tbl%0d_busy", k),  32'(busy), 32'(vt[k].busy));
      chk($sformatf("tbl%0d_addr", k),  rom_addr, vt[k].addr);
      chk($sformatf("tbl%0d_valid", k), 32'(sample_valid), 32'(vt[k].valid));
      if (vt[k].valid) chk($sformatf("tbl%0d_data", k), 32'(sample_data), 32'(vt[k].data));
      start = vt[k].start;
      sample_ready = vt[k].ready;
      cyc();
    end
    // remainder of the clip: 8 transfers, one done
    wait_idle("clip_end_busy");
    chk("clip_xfers", 32'(xfers), 32'd8);
    chk("clip_done",  32'(done_cnt), 32'd1);
    chk("clip_drop",  32'(drop_cnt), 32'd0);
    chk("clip_q",     32'(exp_q.size()), 32'd0);

    // looping: 20 samples with loop on, then clear loop_en, ends after index 7
    for (int p = 0; p < 3; p++) push_clip();
    xfers = 0; done_cnt = 0; loop_en = 1'b1; sample_ready = 1'b1;
    kick();
    begin
      int n = 0;
      while (xfers < 20 && n < 500) begin
        cyc();
        n++;
      end
    end
    chk("loop_xfers20", 32'(xfers), 32'd20);
    chk("loop_nodone",  32'(done_cnt), 32'd0);
    chk("loop_busy",    32'(busy), 32'd1);
    loop_en = 1'b0;
    wait_idle("loop_end_busy");
    chk("loop_xfers", 32'(xfers), 32'd24);
    chk("loop_done",  32'(done_cnt), 32'd1);
    chk("loop_q",     32'(exp_q.size()), 32'd0);

    // backpressure: three dropped samples, then ROM[0] drains and ROM[4] follows
    exp_q.push_back(rom[0]);
    for (int i = 4; i < NS; i++) exp_q.push_back(rom[i]);
    xfers = 0; done_cnt = 0; sample_ready = 1'b0;
    kick();
    begin
      int n = 0;
      while (drop_cnt < 16'd3 && n < 100) begin
        cyc();
        n++;
      end
    end
    chk("bp_drop3", 32'(drop_cnt), 32'd3);
    chk("bp_valid", 32'(sample_valid), 32'd1);
    chk("bp_hold",  32'(sample_data), 32'(rom[0]));
    sample_ready = 1'b1;
    wait_idle("bp_end_busy");
    chk("bp_drop_end", 32'(drop_cnt), 32'd3);
    chk("bp_xfers",    32'(xfers), 32'd5);
    chk("bp_q",        32'(exp_q.size()), 32'd0);

    // transfer and capture in the same cycle, then stop in WAIT_TICK
    exp_q.push_back(rom[0]);
    xfers = 0; done_cnt = 0; sample_ready = 1'b0;
    kick();                                     // S+1
    repeat (5) cyc();                           // S+6: CAPTURE of sample 1
    chk("sim_pre_valid", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    cyc();                                      // S+7
    sample_ready = 1'b0;
    chk("sim_valid", 32'(sample_valid), 32'd1);
    chk("sim_data",  32'(sample_data), 32'(rom[1]));
    chk("sim_drop",  32'(drop_cnt), 32'd0);
    chk("sim_xfers", 32'(xfers), 32'd1);
    stop = 1'b1;
    cyc();                                      // S+8
    stop = 1'b0;
    chk("stop_busy",  32'(busy), 32'd0);
    chk("stop_valid", 32'(sample_valid), 32'd0);
    chk("stop_addr",  rom_addr, 32'd4);
    cyc();
    cyc();
    chk("stop_nodone", 32'(done_cnt), 32'd0);
    chk("stop_q",      32'(exp_q.size()), 32'd0);

    // async reset in a CAPTURE cycle
    kick();
    repeat (5) cyc();
    chk("ar_pre_addr", rom_addr, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_addr",  rom_addr, 32'd0);
    chk("ar_data",  32'(sample_data), 32'd0);
    chk("ar_valid", 32'(sample_valid), 32'd0);
    chk("ar_busy",  32'(busy), 32'd0);
    chk("ar_done",  32'(done), 32'd0);
    chk("ar_drop",  32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("ar_idle", 32'(busy), 32'd0);

    // fresh playback after reset restarts from sample 0
    push_clip();
    xfers = 0; done_cnt = 0; sample_ready = 1'b1;
    kick();
    chk("re_addr", rom_addr, 32'd0);
    chk("re_busy", 32'(busy), 32'd1);
    wait_idle("re_end_busy");
    chk("re_xfers", 32'(xfers), 32'd8);
    chk("re_done",  32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
